// File: rtl/branch_resolve_unit_if.sv
// Bundle between the fetch/execute stages and branch_resolve_unit.
// The stages drive the master side; the resolve unit is the slave.
interface branch_resolve_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             push_valid;
  logic [WIDTH-1:0] push_pc;
  logic             push_taken;
  logic [WIDTH-1:0] push_target;
  logic             resolve_valid;
  logic             resolve_taken;
  logic [WIDTH-1:0] resolve_target;
  logic             flush;
  logic [WIDTH-1:0] save_pc;
  logic             full;
  logic             empty;
  logic             underflow_err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output push_valid, push_pc, push_taken, push_target,
    output resolve_valid, resolve_taken, resolve_target,
    input  flush, save_pc, full, empty, underflow_err, branch_cnt, mispred_cnt
  );

  modport slave (
    input  push_valid, push_pc, push_taken, push_target,
    input  resolve_valid, resolve_taken, resolve_target,
    output flush, save_pc, full, empty, underflow_err, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order branch resolution: queues fetch predictions, checks them against
// execute outcomes, and issues a one-cycle flush/redirect on a mispredict.
module branch_resolve_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  branch_resolve_unit_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] pc_mem     [DEPTH];
  logic [WIDTH-1:0] target_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             flush_q, flush_d;
  logic [WIDTH-1:0] save_pc_q, save_pc_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             resolve_acc;
  logic             pop;
  logic             mispredict;
  logic             push_acc;
  logic [WIDTH-1:0] head_pc;
  logic [WIDTH-1:0] head_target;
  logic             head_taken;
  logic [WIDTH-1:0] correct_pc;

  always_comb begin
    head_pc     = pc_mem[rd_ptr_q];
    head_target = target_mem[rd_ptr_q];
    head_taken  = taken_mem[rd_ptr_q];

    resolve_acc = bus.resolve_valid & ~flush_q;
    pop         = resolve_acc & (occ_q != '0);
    mispredict  = pop & ((head_taken != bus.resolve_taken) |
                         (head_taken & bus.resolve_taken &
                          (head_target != bus.resolve_target)));
    correct_pc  = bus.resolve_taken ? bus.resolve_target : head_pc + WIDTH'(4);

    // A full queue still takes a push when a correct pop frees the head slot.
    push_acc    = bus.push_valid & ~flush_q & ~mispredict &
                  ((occ_q != OCC_FULL) | pop);
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    flush_d       = mispredict;
    save_pc_d     = save_pc_q;
    underflow_d   = underflow_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (mispredict) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      occ_d     = '0;
      save_pc_d = correct_pc;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_acc, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end

    if (resolve_acc && occ_q == '0) underflow_d = 1'b1;
    if (pop && branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (mispredict && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);

    full_d  = (occ_d == OCC_FULL);
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      flush_q       <= 1'b0;
      save_pc_q     <= '0;
      underflow_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      flush_q       <= flush_d;
      save_pc_q     <= save_pc_d;
      underflow_q   <= underflow_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_mem[wr_ptr_q]     <= bus.push_pc;
      target_mem[wr_ptr_q] <= bus.push_target;
      taken_mem[wr_ptr_q]  <= bus.push_taken;
    end
  end

  assign bus.flush         = flush_q;
  assign bus.save_pc       = save_pc_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.underflow_err = underflow_q;
  assign bus.branch_cnt    = branch_cnt_q;
  assign bus.mispred_cnt   = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: default instance plus a CNT_W=4
// instance used for counter saturation.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WIDTH(32), .CNT_W(16)) m_if ();
  branch_resolve_unit_if #(.WIDTH(32), .CNT_W(4))  s_if ();

  branch_resolve_unit #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(m_if.slave));
  branch_resolve_unit #(.WIDTH(32), .DEPTH(4), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .bus(s_if.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tg);
    m_if.push_valid = v; m_if.push_pc = pc; m_if.push_taken = t; m_if.push_target = tg;
  endtask

  task automatic set_res(input logic v, input logic t, input logic [31:0] tg);
    m_if.resolve_valid = v; m_if.resolve_taken = t; m_if.resolve_target = tg;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    set_push(1'b1, pc, t, tg); cyc(); set_push(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_res(input logic t, input logic [31:0] tg);
    set_res(1'b1, t, tg); cyc(); set_res(1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_flush"}, 64'(m_if.flush), 64'd0);
    check({pfx, "_save_pc"}, 64'(m_if.save_pc), 64'd0);
    check({pfx, "_full"}, 64'(m_if.full), 64'd0);
    check({pfx, "_empty"}, 64'(m_if.empty), 64'd1);
    check({pfx, "_underflow"}, 64'(m_if.underflow_err), 64'd0);
    check({pfx, "_branch_cnt"}, 64'(m_if.branch_cnt), 64'd0);
    check({pfx, "_mispred_cnt"}, 64'(m_if.mispred_cnt), 64'd0);
  endtask

  initial begin
    logic        wt [11];
    logic [31:0] wtg [11];

    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b0, 1'b0, '0);
    s_if.push_valid = 1'b0; s_if.push_pc = '0; s_if.push_taken = 1'b0; s_if.push_target = '0;
    s_if.resolve_valid = 1'b0; s_if.resolve_taken = 1'b0; s_if.resolve_target = '0;

    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    check_reset_state("rst");

    // Correct not-taken prediction
    do_push(32'h100, 1'b0, '0);
    check("t1_nonempty", 64'(m_if.empty), 64'd0);
    do_res(1'b0, '0);
    check("t1_flush", 64'(m_if.flush), 64'd0);
    check("t1_empty", 64'(m_if.empty), 64'd1);
    check("t1_bcnt", 64'(m_if.branch_cnt), 64'd1);
    check("t1_mcnt", 64'(m_if.mispred_cnt), 64'd0);

    // Direction mispredict, actually taken
    do_push(32'h200, 1'b0, '0);
    do_res(1'b1, 32'h40);
    check("t2_flush", 64'(m_if.flush), 64'd1);
    check("t2_save_pc", 64'(m_if.save_pc), 64'h40);
    check("t2_mcnt", 64'(m_if.mispred_cnt), 64'd1);
    check("t2_bcnt", 64'(m_if.branch_cnt), 64'd2);
    cyc();
    check("t2_flush_drop", 64'(m_if.flush), 64'd0);
    check("t2_save_hold", 64'(m_if.save_pc), 64'h40);

    // Direction mispredict, actually not taken -> pc+4
    do_push(32'h300, 1'b1, 32'h80);
    do_res(1'b0, '0);
    check("t2b_flush", 64'(m_if.flush), 64'd1);
    check("t2b_save_pc", 64'(m_if.save_pc), 64'h304);
    check("t2b_mcnt", 64'(m_if.mispred_cnt), 64'd2);
    cyc();

    // Target mispredict
    do_push(32'h10, 1'b1, 32'h50);
    do_res(1'b1, 32'h60);
    check("t3_flush", 64'(m_if.flush), 64'd1);
    check("t3_save_pc", 64'(m_if.save_pc), 64'h60);
    check("t3_mcnt", 64'(m_if.mispred_cnt), 64'd3);
    cyc();

    // Mispredict with 3 queued; pushes in mispredict and flush cycles dropped
    do_push(32'h20, 1'b0, '0);
    do_push(32'h24, 1'b0, '0);
    do_push(32'h28, 1'b0, '0);
    check("t3_three_full", 64'(m_if.full), 64'd0);
    set_push(1'b1, 32'h30, 1'b0, '0);
    set_res(1'b1, 1'b1, 32'h98);
    cyc();
    check("t3_clr_flush", 64'(m_if.flush), 64'd1);
    check("t3_clr_save", 64'(m_if.save_pc), 64'h98);
    check("t3_clr_empty", 64'(m_if.empty), 64'd1);
    check("t3_clr_bcnt", 64'(m_if.branch_cnt), 64'd5);
    check("t3_clr_mcnt", 64'(m_if.mispred_cnt), 64'd4);
    set_push(1'b1, 32'h34, 1'b0, '0);
    set_res(1'b1, 1'b0, '0);
    cyc();
    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b0, 1'b0, '0);
    check("t3_fl_flush", 64'(m_if.flush), 64'd0);
    check("t3_fl_empty", 64'(m_if.empty), 64'd1);
    check("t3_fl_underflow", 64'(m_if.underflow_err), 64'd0);
    check("t3_fl_bcnt", 64'(m_if.branch_cnt), 64'd5);

    // Fill, overflow drop, push+pop while full
    for (int i = 0; i < 4; i++) begin
      check("t4_not_full", 64'(m_if.full), 64'd0);
      do_push(32'h1000 + 32'(4 * i), 1'b0, '0);
    end
    check("t4_full", 64'(m_if.full), 64'd1);
    do_push(32'h2000, 1'b0, '0);
    check("t4_drop_full", 64'(m_if.full), 64'd1);
    set_push(1'b1, 32'h1010, 1'b0, '0);
    set_res(1'b1, 1'b0, '0);
    cyc();
    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b0, 1'b0, '0);
    check("t4_pp_full", 64'(m_if.full), 64'd1);
    check("t4_pp_flush", 64'(m_if.flush), 64'd0);
    check("t4_pp_bcnt", 64'(m_if.branch_cnt), 64'd6);
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_empty", 64'(m_if.empty), 64'd0);
      do_res(1'b0, '0);
      check("t4_drain_flush", 64'(m_if.flush), 64'd0);
    end
    check("t4_drained", 64'(m_if.empty), 64'd1);
    check("t4_bcnt", 64'(m_if.branch_cnt), 64'd10);

    // Pointer wrap: alternating directions expose any reordering as a flush
    for (int i = 0; i < 11; i++) begin
      wt[i]  = 1'(i % 2);
      wtg[i] = 32'h5000 + 32'(8 * i);
    end
    do_push(32'h4000, wt[0], wtg[0]);
    for (int i = 1; i < 11; i++) begin
      set_push(1'b1, 32'h4000 + 32'(4 * i), wt[i], wtg[i]);
      set_res(1'b1, wt[i-1], wtg[i-1]);
      cyc();
      check("t4_wrap_flush", 64'(m_if.flush), 64'd0);
      check("t4_wrap_empty", 64'(m_if.empty), 64'd0);
    end
    set_push(1'b0, '0, 1'b0, '0);
    set_res(1'b0, 1'b0, '0);
    do_res(wt[10], wtg[10]);
    check("t4_wrap_last_flush", 64'(m_if.flush), 64'd0);
    check("t4_wrap_empty_end", 64'(m_if.empty), 64'd1);
    check("t4_wrap_bcnt", 64'(m_if.branch_cnt), 64'd21);
    check("t4_wrap_mcnt", 64'(m_if.mispred_cnt), 64'd4);

    do_push(32'h7000, 1'b1, 32'h7100);
    do_res(1'b0, '0);
    check("t4_post_wrap_flush", 64'(m_if.flush), 64'd1);
    check("t4_post_wrap_save", 64'(m_if.save_pc), 64'h7004);
    check("t4_post_wrap_mcnt", 64'(m_if.mispred_cnt), 64'd5);
    cyc();

    // Underflow
    do_res(1'b0, '0);
    check("t5_underflow", 64'(m_if.underflow_err), 64'd1);
    check("t5_uf_bcnt", 64'(m_if.branch_cnt), 64'd22);
    check("t5_uf_flush", 64'(m_if.flush), 64'd0);
    cyc(); cyc();
    check("t5_uf_sticky", 64'(m_if.underflow_err), 64'd1);

    // Reset with 3 queued
    do_push(32'h8000, 1'b0, '0);
    do_push(32'h8004, 1'b0, '0);
    do_push(32'h8008, 1'b0, '0);
    check("t5_q3_empty", 64'(m_if.empty), 64'd0);
    reset = 1'b1;
    set_push(1'b1, 32'h9000, 1'b0, '0);
    cyc();
    reset = 1'b0;
    set_push(1'b0, '0, 1'b0, '0);
    check_reset_state("t5_rst");

    // Saturation on CNT_W=4 instance
    for (int i = 0; i < 20; i++) begin
      s_if.push_valid = 1'b1; s_if.push_pc = 32'h600 + 32'(4 * i); s_if.push_taken = 1'b0;
      cyc();
      s_if.push_valid = 1'b0;
      s_if.resolve_valid = 1'b1; s_if.resolve_taken = 1'b1; s_if.resolve_target = 32'h44;
      cyc();
      s_if.resolve_valid = 1'b0;
      if (i == 0) check("t6_first_mcnt", 64'(s_if.mispred_cnt), 64'd1);
      if (i == 14) check("t6_at_max", 64'(s_if.mispred_cnt), 64'd15);
      check("t6_flush", 64'(s_if.flush), 64'd1);
      cyc();
    end
    check("t6_sat_mcnt", 64'(s_if.mispred_cnt), 64'd15);
    check("t6_sat_bcnt", 64'(s_if.branch_cnt), 64'd15);
    check("t6_sat_save", 64'(s_if.save_pc), 64'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks every branch the fetch stage predicts and resolves each one in program order when execute reports its real outcome. On a misprediction it produces the `flush` pulse and the `save_pc` redirect address consumed by the PC register. It also discards all younger in-flight predictions and keeps saturating accuracy counters for the perceptron tuning runs. It sits between the predictor/fetch stage (push side) and the execute-stage branch comparator (resolve side).

## Interface
- WIDTH, 32, PC/address width in bits.
- DEPTH, 4, in-flight branch queue entries; power of two, ≥2.
- CNT_W, 16, statistics counter width.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- push_valid  in  1  fetch predicted a branch this cycle.
- push_pc  in  WIDTH  address of that branch.
- push_taken  in  1  predicted direction.
- push_target  in  WIDTH  predicted target (meaningful when push_taken=1).
- resolve_valid  in  1  execute resolved the oldest branch this cycle.
- resolve_taken  in  1  actual direction.
- resolve_target  in  WIDTH  actual target.
- flush  out  1  one-cycle redirect pulse to PC register / pipeline.
- save_pc  out  WIDTH  correct next PC, valid while flush=1.
- full  out  1  queue holds DEPTH entries.
- empty  out  1  queue holds 0 entries.
- underflow_err  out  1  sticky: resolve arrived with queue empty.
- branch_cnt  out  CNT_W  branches resolved, saturating.
- mispred_cnt  out  CNT_W  mispredictions, saturating.

## Operation
- Queue: circular FIFO, entries {pc, taken, target}; write/read pointers log2(DEPTH) bits wrap modulo DEPTH; occupancy counter 0..DEPTH drives full/empty.
- A push is accepted when push_valid=1, full=0, flush=0, and no mispredict is being detected this cycle. Otherwise it is dropped silently: no state change, counters unaffected.
- Exception: push_valid=1 while full=1 is accepted when the same cycle has an accepted, correctly-predicted resolve (pop frees the slot).
- A resolve is accepted when resolve_valid=1 and flush=0. It pops the oldest entry and compares against it:
  - mispredict = (entry.taken != resolve_taken) OR (entry.taken & resolve_taken & entry.target != resolve_target).
  - Correct PC = resolve_target if resolve_taken, else entry.pc + 4 (WIDTH-bit wrap).
- On mispredict: next cycle flush=1 and save_pc=correct PC. The queue is cleared on the same edge (pointers and occupancy to 0). Any same-cycle push is discarded.
- resolve_valid=1 with empty=1 (and flush=0): no pop, no counter change, underflow_err set until reset.
- resolve_valid=1 while flush=1: ignored entirely, including the underflow check.
- Counters: branch_cnt +1 per accepted non-underflow resolve; mispred_cnt +1 per mispredict. Both hold at 2^CNT_W−1.

## Timing
- Reset values: flush=0, save_pc=0, full=0, empty=1, underflow_err=0, branch_cnt=0, mispred_cnt=0; queue empty, pointers 0.
- Reset has priority over all inputs in the same cycle. Reset mid-flush or with a full queue clears everything in one edge.
- All outputs are registered.
- Resolve-to-flush latency is 1 cycle. flush is high for exactly 1 cycle per mispredict and never high on back-to-back cycles, because resolves are ignored while flush=1.
- save_pc holds its last value when flush=0.
- Push-to-visible latency is 1 cycle: a branch pushed at edge N can be resolved in the cycle after edge N. full/empty reflect post-edge occupancy.
- When push and pop are accepted in the same cycle, occupancy is unchanged.

## Test plan
- Reset, then push {pc=0x100, taken=0}, resolve taken=0 → no flush; branch_cnt=1, mispred_cnt=0; empty=1.
- Push {0x200, taken=0}, resolve taken=1 target=0x40 → next cycle flush=1, save_pc=0x40 for 1 cycle; mispred_cnt=1. Push {0x300, taken=1, 0x80}, resolve taken=0 → flush=1, save_pc=0x304.
- Push {0x10, 1, 0x50}, resolve taken=1 target=0x60 → flush=1, save_pc=0x60. Push 3 more entries, mispredict the first → all cleared, empty=1; a push in the mispredict cycle and a push in the flush cycle are both dropped.
- Fill DEPTH=4 entries → full=1, extra push dropped. Simultaneous correct resolve and push while full → occupancy stays 4. Pointers wrap after 10 push/pop pairs; FIFO order is preserved across the wrap.
- Resolve with empty=1 → underflow_err=1, sticky, branch_cnt unchanged. Resolve during flush=1 → ignored. Assert reset with 3 entries queued → all outputs at reset values next cycle.
- With CNT_W=4, run 20 mispredicts → mispred_cnt saturates at 15.
